// File: rtl/clk_pkg.sv
// Shared constants for the clock divider bank.
// Divide values give a half-period of (DIV+1) master_clk cycles, so an output
// of frequency f needs DIV = MCLK_HZ / (2*f) - 1.
package clk_pkg;

  localparam int unsigned CNT_W_DEF = 27;
  localparam int unsigned MCLK_HZ   = 100_000_000;

  // Named divide values for the game consumers (100 MHz master clock).
  localparam int unsigned DIV_SHIP     = 99_999;      // 500 Hz toggle
  localparam int unsigned DIV_PROJ     = 299_999;
  localparam int unsigned DIV_ALIEN    = 2_999_999;
  localparam int unsigned DIV_COOLDOWN = 99_999_999;
  localparam int unsigned DIV_25M      = 1;           // video pixel clock

  // Divide value for a requested toggle-clock frequency in Hz.
  function automatic int unsigned div_for_hz(input int unsigned hz);
    return MCLK_HZ / (2 * hz) - 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// Single programmable divider channel.
// Ports:
//   clk, rst_n  master clock, asynchronous active-low reset
//   run         count enable; 0 freezes cnt and clk_out
//   restart     phase-align: clear cnt/clk_out, apply any pending shadow
//   we, now     write strobe for this channel; now applies immediately
//   div         divide value written by we
//   tick        one-cycle pulse per half-period (registered)
//   clk_out     50% toggle clock (registered)
//   pending     a shadow value is waiting for the next wrap
module clock_divider_channel
  import clk_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DIV_SHIP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic             we,
  input  logic             now,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             clk_out,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             wrap;

  // Equality is enough: act only changes at a wrap, with cnt cleared, or at restart.
  assign wrap = (cnt_q == act_q);

  always_comb begin
    cnt_d    = cnt_q;
    act_d    = act_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    clk_d    = clk_q;
    if (restart) begin
      // A same-cycle write lands first and is applied by the restart.
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      if (we) begin
        shadow_d = div;
        act_d    = div;
      end else if (pend_q) begin
        act_d = shadow_q;
      end
    end else if (we && now) begin
      cnt_d    = '0;
      act_d    = div;
      shadow_d = div;
      pend_d   = 1'b0;
    end else begin
      if (run) begin
        if (wrap) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = 1'b1;
          // The half-period just ended used the old value; switch for the next one.
          if (pend_q) begin
            act_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A deferred write always leaves a fresh pending value, even on a wrap cycle.
      if (we) begin
        shadow_d = div;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      act_q    <= DefDiv;
      shadow_q <= DefDiv;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;
  assign pending = pend_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers.
// Ports:
//   master_clk         system clock
//   RESET_debounced_n  asynchronous active-low reset
//   run                per-channel count enable
//   restart            synchronous pulse, phase-aligns all channels
//   cfg_we/ch/div/now  configuration write (now = apply immediately)
//   cfg_ack, cfg_err   one-cycle response: write accepted / channel out of range
//   pending            per-channel shadow waiting for next wrap
//   tick, clk_out      per-channel tick enable and 50% toggle clock
module clock_divider_bank
  import clk_pkg::*;
#(
  parameter int unsigned NUM_CH  = 5,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DIV_SHIP,
  parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              master_clk,
  input  logic              RESET_debounced_n,
  input  logic [NUM_CH-1:0] run,
  input  logic              restart,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_now,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic              cfg_valid;
  logic [NUM_CH-1:0] ch_we;
  logic              ack_q, err_q;

  assign cfg_valid = 32'(cfg_ch) < NUM_CH;

  always_comb begin
    ch_we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_we[i] = cfg_we && cfg_valid && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge master_clk or negedge RESET_debounced_n) begin
    if (!RESET_debounced_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= cfg_we && cfg_valid;
      err_q <= cfg_we && !cfg_valid;
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (master_clk),
      .rst_n   (RESET_debounced_n),
      .run     (run[g]),
      .restart (restart),
      .we      (ch_we[g]),
      .now     (cfg_now),
      .div     (cfg_div),
      .tick    (tick[g]),
      .clk_out (clk_out[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parametrised, runtime-programmable replacement for the fixed-ratio game clock divider.
- Generates NUM_CH independent divided outputs from master_clk, each as a 50% toggle clock and a one-cycle tick enable.
- Divide ratios are reprogrammable without glitches, and all channels can be phase-aligned by a single restart pulse.
- Consumers are the ship, projectile, alien, cooldown and video timing logic. New logic uses tick; clk_out is kept for legacy consumers.

Parameters:
- NUM_CH, 5, number of divider channels (1..16)
- CNT_W, 27, counter and divide-value width
- DEF_DIV, 99_999, reset divide value loaded into every channel
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select

Ports:
- master_clk  in  1  100 MHz system clock
- RESET_debounced_n  in  1  asynchronous active-low reset
- run  in  NUM_CH  per-channel count enable; 0 freezes the channel
- restart  in  1  synchronous pulse; phase-aligns all channels
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel addressed by cfg_we
- cfg_div  in  CNT_W  new divide value; half-period = cfg_div+1 cycles
- cfg_now  in  1  with cfg_we, apply immediately instead of at the next wrap
- cfg_ack  out  1  one-cycle pulse, write accepted
- cfg_err  out  1  one-cycle pulse, write rejected (cfg_ch >= NUM_CH)
- pending  out  NUM_CH  shadow value waiting for the next wrap
- tick  out  NUM_CH  one-cycle pulse per half-period
- clk_out  out  NUM_CH  toggles once per half-period

Behaviour:
- Reset, asynchronous with RESET_debounced_n=0:
  - every cnt=0, div_act=div_shadow=DEF_DIV
  - all outputs 0: tick, clk_out, pending, cfg_ack, cfg_err
- Channel counting (run[i]=1):
  - cnt increments by 1 each cycle.
  - When cnt==div_act: cnt goes to 0 (wrap), clk_out[i] toggles, and tick[i]=1 for exactly the following cycle.
  - All outputs are registered. tick and the clk_out edge appear together, 1 cycle after the wrap compare.
- div_act=0: tick is held high continuously and clk_out toggles every cycle (master/2).
- run[i]=0:
  - cnt and clk_out hold their values; tick[i]=0.
  - Resuming continues from the held cnt, with no extra tick.
- Config write (cfg_we=1, cfg_ch<NUM_CH):
  - div_shadow[cfg_ch]=cfg_div and pending set; cfg_ack=1 next cycle.
  - At the next wrap of that channel, div_act takes div_shadow and pending clears. The half-period just ending uses the old value, so no runt pulse.
- Write while pending: the shadow is overwritten; only the last value is applied.
- cfg_now=1: div_act and div_shadow load at once, cnt is cleared to 0, clk_out holds, no tick, pending cleared.
- Write to a frozen channel (run=0): stays pending until the channel runs and wraps. cfg_now still applies immediately.
- Out-of-range write (cfg_ch>=NUM_CH): no state change; cfg_err=1 next cycle; cfg_ack=0.
- restart=1 has priority over counting, and run is ignored that cycle:
  - all cnt=0, clk_out=0, tick=0
  - every pending shadow is copied into div_act and pending clears
  - a cfg_we in the same cycle is written first, then applied by the restart, and is acked
- Reset mid-operation: returns to the reset state immediately, regardless of master_clk.
- Arithmetic: compare uses equality only; cnt never exceeds div_act because div_act changes only at wrap, under cfg_now (with cnt cleared) or at restart.

Decomposition:
- Shared package clk_pkg:
  - CNT_W default
  - system clock frequency constant MCLK_HZ=100_000_000
  - named divide constants: DIV_SHIP=99_999, DIV_PROJ=299_999, DIV_ALIEN=2_999_999, DIV_COOLDOWN=99_999_999, DIV_25M=1
- One sub-module, clock_divider_channel:
  - holds cnt, div_act, div_shadow, pending, tick and clk_out for a single channel
  - instantiated NUM_CH times in a generate loop
- The top level contains only write decode, cfg_ack/cfg_err and restart fan-out.

Test Plan:
- Reset, then DEF_DIV=3, run=all 1 -> tick pulses every 4 cycles, clk_out period 8 cycles, first tick 4 cycles after run rises.
- Channel 0 at div 3; write cfg_div=1 to ch0 mid-period -> pending[0]=1 and cfg_ack pulses. The current half-period completes at 4 cycles, then ticks come every 2 cycles and pending clears.
- Write cfg_div=0 with cfg_now=1 to ch1 -> cnt cleared; tick[1] high every cycle from the 2nd cycle on; clk_out[1] toggles every cycle.
- run[2]=0 for 10 cycles mid-count (cnt=2 of div 3) -> no ticks and clk_out[2] held. After resume, the next tick comes 2 cycles later.
- Channels left unaligned, then restart with a simultaneous cfg_we ch3 div=5 -> all clk_out=0 and cnt=0. Ch3 ticks every 6 cycles, the others at their old divides, all phase-aligned; cfg_ack pulses.
- cfg_we with cfg_ch=7 (NUM_CH=5) -> cfg_err pulses, cfg_ack=0, no pending bit set. Assert RESET_debounced_n low between clock edges -> outputs go to 0 immediately.
